// File: rtl/dispatch_pkg.sv
// Shared types and default widths for the N-wide dispatch buffer between rename and the RS/ROB.
package dispatch_pkg;

    localparam int unsigned DefWidth     = 2;
    localparam int unsigned DefDepth     = 8;
    localparam int unsigned DefNumCdb    = 2;
    localparam int unsigned DefNumClass  = 4;
    localparam int unsigned PhysRegWidth = 6;
    localparam int unsigned CobDepth     = 4;
    localparam int unsigned DefCntWidth  = 4;
    localparam int unsigned PayloadWidth = 16;

    typedef enum logic [1:0] {
        RsInt = 2'd0,
        RsMud = 2'd1,
        RsBra = 2'd2,
        RsMem = 2'd3
    } rs_class_e;

    typedef struct packed {
        rs_class_e                 cls;
        logic [PhysRegWidth-1:0]   prs1;
        logic                      prs1_ready;
        logic [PhysRegWidth-1:0]   prs2;
        logic                      prs2_ready;
        logic [CobDepth-1:0]       branch_mask;
        logic [PayloadWidth-1:0]   payload;
    } disp_op_t;

endpackage

// File: rtl/dispatch_select.sv
// In-order prefix selector: slot k is released only if slots 0..k-1 are, the ROB has k+1 free
// entries, and the target RS class has room for every same-class op in slots 0..k.
module dispatch_select
    import dispatch_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned NUM_CLASS = DefNumClass,
    parameter int unsigned CNT_WIDTH = DefCntWidth
) (
    input  logic [WIDTH-1:0]                      valid,
    input  rs_class_e [WIDTH-1:0]                 cls,
    input  logic [NUM_CLASS-1:0][CNT_WIDTH-1:0]   rs_free,
    input  logic [CNT_WIDTH-1:0]                  rob_free,
    output logic [WIDTH-1:0]                      sel
);

    always_comb begin
        int  same_cnt;
        logic run;
        sel      = '0;
        run      = 1'b1;
        same_cnt = 0;
        for (int k = 0; k < WIDTH; k++) begin
            same_cnt = 0;
            for (int j = 0; j <= k; j++) begin
                if (cls[j] == cls[k]) begin
                    same_cnt = same_cnt + 1;
                end
            end
            run = run && valid[k] && ((k + 1) <= int'(rob_free))
                      && (same_cnt <= int'(rs_free[cls[k]]));
            sel[k] = run;
        end
    end

endmodule

// File: rtl/dispatch_nway.sv
// N-wide in-order dispatch queue with CDB snoop, branch clean/kill and credit-limited release.
// Define DISPATCH_BYPASS_EN to let incoming ops dispatch in the same cycle when the queue is empty.
module dispatch_nway
    import dispatch_pkg::*;
#(
    parameter int unsigned WIDTH          = DefWidth,
    parameter int unsigned DEPTH          = DefDepth,
    parameter int unsigned NUM_CDB        = DefNumCdb,
    parameter int unsigned NUM_CLASS      = DefNumClass,
    parameter int unsigned PHYS_REG_WIDTH = PhysRegWidth,
    parameter int unsigned COB_DEPTH      = CobDepth,
    parameter int unsigned CNT_WIDTH      = DefCntWidth
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [WIDTH-1:0]                        in_valid,
    input  disp_op_t [WIDTH-1:0]                    in_op,
    output logic                                    in_ready,
    output logic [WIDTH-1:0]                        out_valid,
    output disp_op_t [WIDTH-1:0]                    out_op,
    input  logic [NUM_CLASS-1:0][CNT_WIDTH-1:0]     rs_free,
    input  logic [CNT_WIDTH-1:0]                    rob_free,
    input  logic [NUM_CDB-1:0]                      cdb_valid,
    input  logic [NUM_CDB-1:0][PHYS_REG_WIDTH-1:0]  cdb_prd,
    input  logic                                    br_valid,
    input  logic [$clog2(COB_DEPTH)-1:0]            br_tag,
    input  logic                                    br_clean,
    input  logic                                    br_kill,
    input  logic                                    flush,
    output logic [$clog2(DEPTH):0]                  occupancy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(COB_DEPTH);

    disp_op_t             mem_q [DEPTH];
    disp_op_t             mem_d [DEPTH];
    logic [PW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
    logic [PW-1:0]        occ, surv;
    logic                 kill_en, clean_en, byp;
    logic [WIDTH-1:0]     in_keep, cand_valid, sel;
    disp_op_t [WIDTH-1:0] cand_op;
    rs_class_e [WIDTH-1:0] cand_cls;

    // Applies same-cycle CDB wakeups (prd 0 never wakes anything) and a branch clean.
    function automatic disp_op_t snoop(input disp_op_t op,
                                       input logic [NUM_CDB-1:0] cv,
                                       input logic [NUM_CDB-1:0][PHYS_REG_WIDTH-1:0] cp,
                                       input logic ce,
                                       input logic [TW-1:0] tag);
        disp_op_t r;
        r = op;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cv[c] && (cp[c] != '0)) begin
                if (cp[c] == r.prs1) r.prs1_ready = 1'b1;
                if (cp[c] == r.prs2) r.prs2_ready = 1'b1;
            end
        end
        if (ce) r.branch_mask[tag] = 1'b0;
        return r;
    endfunction

    assign occ       = wptr_q - rptr_q;
    assign occupancy = occ;
    assign kill_en   = br_valid & br_kill & ~flush;
    assign clean_en  = br_valid & br_clean & ~br_kill & ~flush;

    // Surviving entries: killed ops form a suffix, so count the live prefix from the head.
    always_comb begin
        logic alive;
        alive = 1'b1;
        surv  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (PW'(i) < occ) begin
                alive = alive && !(kill_en && mem_q[rptr_q[AW-1:0] + AW'(i)].branch_mask[br_tag]);
                if (alive) surv = surv + PW'(1);
            end
        end
        in_keep = '0;
        alive   = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            alive      = alive && in_valid[k] && !(kill_en && in_op[k].branch_mask[br_tag]);
            in_keep[k] = alive;
        end
    end

`ifdef DISPATCH_BYPASS_EN
    assign byp = (surv == '0);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            if (byp) begin
                cand_op[k]    = snoop(in_op[k], cdb_valid, cdb_prd, clean_en, br_tag);
                cand_valid[k] = in_keep[k];
            end else begin
                cand_op[k]    = snoop(mem_q[rptr_q[AW-1:0] + AW'(k)], cdb_valid, cdb_prd,
                                      clean_en, br_tag);
                cand_valid[k] = (PW'(k) < surv);
            end
            cand_cls[k] = cand_op[k].cls;
        end
    end

    dispatch_select #(
        .WIDTH     (WIDTH),
        .NUM_CLASS (NUM_CLASS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_select (
        .valid    (cand_valid),
        .cls      (cand_cls),
        .rs_free  (rs_free),
        .rob_free (rob_free),
        .sel      (sel)
    );

    assign out_op = cand_op;

    always_comb begin
        int            n_out;
        int            n_wr;
        int            n_skip;
        logic [PW-1:0] wbase;
        out_valid = sel & {WIDTH{~flush & ~rst}};
        n_out     = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (out_valid[k]) n_out = n_out + 1;
        end
        if (byp) begin
            in_ready = 1'b1;
        end else begin
            in_ready = (int'(DEPTH) - (int'(surv) - n_out)) >= int'(WIDTH);
        end

        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = snoop(mem_q[i], cdb_valid, cdb_prd, clean_en, br_tag);
        end
        // After a kill the write point is the oldest killed slot; otherwise it equals wptr_q.
        wbase  = rptr_q + surv;
        n_skip = byp ? n_out : 0;
        n_wr   = 0;
        if (in_ready && !flush) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (in_keep[k] && (k >= n_skip)) begin
                    mem_d[wbase[AW-1:0] + AW'(n_wr)] = snoop(in_op[k], cdb_valid, cdb_prd,
                                                             clean_en, br_tag);
                    n_wr = n_wr + 1;
                end
            end
        end
        rptr_d = rptr_q + (byp ? '0 : PW'(n_out));
        wptr_d = wbase + PW'(n_wr);
        if (flush) begin
            rptr_d = '0;
            wptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_dispatch_nway.sv
// Scoreboard bench for dispatch_nway: directed stimulus pushes expected dispatched ops, a monitor
// pops and compares every op the DUT presents.
module tb_dispatch_nway;
    import dispatch_pkg::*;

    localparam int W   = 2;
    localparam int D   = 8;
    localparam int NC  = 2;
    localparam int NCL = 4;
    localparam int PRW = PhysRegWidth;
    localparam int CW  = 4;
    localparam int TW  = $clog2(CobDepth);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [W-1:0]            in_valid;
    disp_op_t [W-1:0]        in_op;
    logic                    in_ready;
    logic [W-1:0]            out_valid;
    disp_op_t [W-1:0]        out_op;
    logic [NCL-1:0][CW-1:0]  rs_free;
    logic [CW-1:0]           rob_free;
    logic [NC-1:0]           cdb_valid;
    logic [NC-1:0][PRW-1:0]  cdb_prd;
    logic                    br_valid;
    logic [TW-1:0]           br_tag;
    logic                    br_clean;
    logic                    br_kill;
    logic                    flush;
    logic [$clog2(D):0]      occupancy;

    disp_op_t exp_q[$];
    disp_op_t mon_exp;
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dispatch_nway #(
        .WIDTH          (W),
        .DEPTH          (D),
        .NUM_CDB        (NC),
        .NUM_CLASS      (NCL),
        .PHYS_REG_WIDTH (PRW),
        .COB_DEPTH      (CobDepth),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_op    (out_op),
        .rs_free   (rs_free),
        .rob_free  (rob_free),
        .cdb_valid (cdb_valid),
        .cdb_prd   (cdb_prd),
        .br_valid  (br_valid),
        .br_tag    (br_tag),
        .br_clean  (br_clean),
        .br_kill   (br_kill),
        .flush     (flush),
        .occupancy (occupancy)
    );

    function automatic disp_op_t mk(input rs_class_e c, input int p1, input bit r1,
                                     input int p2, input bit r2, input int m, input int pl);
        disp_op_t o;
        o.cls         = c;
        o.prs1        = PRW'(p1);
        o.prs1_ready  = r1;
        o.prs2        = PRW'(p2);
        o.prs2_ready  = r2;
        o.branch_mask = CobDepth'(m);
        o.payload     = PayloadWidth'(pl);
        return o;
    endfunction

    function automatic disp_op_t plain(input rs_class_e c, input int pl);
        return mk(c, 1, 1'b1, 2, 1'b1, 0, pl);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        in_valid  = '0;
        cdb_valid = '0;
        cdb_prd   = '0;
        br_valid  = 1'b0;
        br_clean  = 1'b0;
        br_kill   = 1'b0;
        br_tag    = '0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (occupancy == 0) break;
            step();
        end
        chk("drain_occupancy", 64'(occupancy), 64'd0);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < W; k++) begin
            if (out_valid[k]) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_dispatch: got payload 0x%0h expected none at %0t",
                             out_op[k].payload, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("dispatch_op", 64'(out_op[k]), 64'(mon_exp));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_op     = '0;
        cdb_valid = '0;
        cdb_prd   = '0;
        br_valid  = 1'b0;
        br_tag    = '0;
        br_clean  = 1'b0;
        br_kill   = 1'b0;
        flush     = 1'b0;
        rob_free  = '0;
        rs_free   = {NCL{4'hF}};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        step();

        // Credit limit: one int RS slot per cycle.
        rob_free = 4'd0;
        in_op[0] = plain(RsInt, 1);
        in_op[1] = plain(RsInt, 2);
        in_valid = 2'b11;
        exp_q.push_back(plain(RsInt, 1));
        exp_q.push_back(plain(RsInt, 2));
        step();
        chk("credit_occupancy", 64'(occupancy), 64'd2);
        rob_free   = 4'd4;
        rs_free[0] = 4'd1;
        @(negedge clk);
        chk("credit_out_valid_a", 64'(out_valid), 64'b01);
        step();
        @(negedge clk);
        chk("credit_out_valid_b", 64'(out_valid), 64'b01);
        step();
        chk("credit_empty", 64'(occupancy), 64'd0);

        // In-order blocking behind a starved mud head.
        rob_free = 4'd0;
        rs_free  = {NCL{4'hF}};
        in_op[0] = plain(RsMud, 3);
        in_op[1] = plain(RsInt, 4);
        in_valid = 2'b11;
        exp_q.push_back(plain(RsMud, 3));
        exp_q.push_back(plain(RsInt, 4));
        step();
        rob_free   = 4'd4;
        rs_free[1] = 4'd0;
        rs_free[0] = 4'd3;
        @(negedge clk);
        chk("block_out_valid", 64'(out_valid), 64'b00);
        step();
        rs_free[1] = 4'd1;
        @(negedge clk);
        chk("resume_out_valid", 64'(out_valid), 64'b11);
        step();

        // Fill to DEPTH, then refill while dequeuing.
        rob_free = 4'd0;
        rs_free  = {NCL{4'hF}};
        for (int i = 0; i < 4; i++) begin
            in_op[0] = plain(RsInt, 10 + 2 * i);
            in_op[1] = plain(RsInt, 11 + 2 * i);
            in_valid = 2'b11;
            exp_q.push_back(plain(RsInt, 10 + 2 * i));
            exp_q.push_back(plain(RsInt, 11 + 2 * i));
            step();
        end
        chk("full_occupancy", 64'(occupancy), 64'd8);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rob_free = 4'd2;
        in_op[0] = plain(RsInt, 18);
        in_op[1] = plain(RsInt, 19);
        in_valid = 2'b11;
        exp_q.push_back(plain(RsInt, 18));
        exp_q.push_back(plain(RsInt, 19));
        @(negedge clk);
        chk("refill_in_ready", 64'(in_ready), 64'd1);
        chk("refill_out_valid", 64'(out_valid), 64'b11);
        step();
        chk("refill_occupancy", 64'(occupancy), 64'd8);
        rob_free = 4'hF;
        drain();

        // CDB snoop: queued wakeup, same-cycle wakeup, prd 0 ignored.
        rob_free = 4'd0;
        in_op[0] = mk(RsInt, 5, 1'b0, 0, 1'b0, 0, 20);
        in_op[1] = mk(RsInt, 9, 1'b0, 3, 1'b1, 0, 21);
        in_valid = 2'b11;
        exp_q.push_back(mk(RsInt, 5, 1'b1, 0, 1'b0, 0, 20));
        exp_q.push_back(mk(RsInt, 9, 1'b1, 3, 1'b1, 0, 21));
        step();
        cdb_valid  = 2'b10;
        cdb_prd[1] = PRW'(5);
        step();
        rob_free   = 4'd4;
        cdb_valid  = 2'b11;
        cdb_prd[0] = PRW'(9);
        cdb_prd[1] = PRW'(0);
        @(negedge clk);
        chk("snoop_out_valid", 64'(out_valid), 64'b11);
        step();

        // Branch kill of a queued suffix, then kill with concurrent enqueue.
        rob_free = 4'd0;
        in_op[0] = plain(RsInt, 30);
        in_op[1] = plain(RsInt, 31);
        in_valid = 2'b11;
        exp_q.push_back(plain(RsInt, 30));
        exp_q.push_back(plain(RsInt, 31));
        step();
        in_op[0] = mk(RsInt, 1, 1'b1, 2, 1'b1, 4'b0010, 32);
        in_op[1] = mk(RsInt, 1, 1'b1, 2, 1'b1, 4'b0010, 33);
        in_valid = 2'b11;
        step();
        chk("prekill_occupancy", 64'(occupancy), 64'd4);
        br_valid = 1'b1;
        br_kill  = 1'b1;
        br_tag   = TW'(1);
        step();
        chk("kill_occupancy", 64'(occupancy), 64'd2);
        br_valid = 1'b1;
        br_kill  = 1'b1;
        br_tag   = TW'(1);
        in_op[0] = plain(RsInt, 34);
        in_op[1] = mk(RsInt, 1, 1'b1, 2, 1'b1, 4'b0010, 35);
        in_valid = 2'b11;
        exp_q.push_back(plain(RsInt, 34));
        step();
        chk("kill_enq_occupancy", 64'(occupancy), 64'd3);
        rob_free = 4'hF;
        drain();

        // Branch clean on a queued op shows up on the dispatched mask.
        rob_free = 4'd0;
        in_op[0] = mk(RsBra, 1, 1'b1, 2, 1'b1, 4'b0100, 40);
        in_valid = 2'b01;
        exp_q.push_back(mk(RsBra, 1, 1'b1, 2, 1'b1, 4'b0000, 40));
        step();
        rob_free = 4'd4;
        br_valid = 1'b1;
        br_clean = 1'b1;
        br_tag   = TW'(2);
        @(negedge clk);
        chk("clean_out_valid", 64'(out_valid), 64'b01);
        step();
        chk("clean_occupancy", 64'(occupancy), 64'd0);

        // Stream across the pointer wrap, then flush.
        rob_free = 4'hF;
        for (int i = 0; i < 20; i++) begin
            in_op[0] = plain(RsMem, 100 + i);
            in_valid = 2'b01;
            exp_q.push_back(plain(RsMem, 100 + i));
            step();
        end
        step();
        chk("wrap_occupancy", 64'(occupancy), 64'd0);
        rob_free = 4'd0;
        in_op[0] = plain(RsInt, 200);
        in_op[1] = plain(RsInt, 201);
        in_valid = 2'b11;
        step();
        chk("preflush_occupancy", 64'(occupancy), 64'd2);
        rob_free = 4'hF;
        flush    = 1'b1;
        in_op[0] = plain(RsInt, 202);
        in_op[1] = plain(RsInt, 203);
        in_valid = 2'b11;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        step();
        chk("postflush_occupancy", 64'(occupancy), 64'd0);
        @(negedge clk);
        chk("postflush_out_valid", 64'(out_valid), 64'd0);
        chk("postflush_in_ready", 64'(in_ready), 64'd1);
        step();

        chk("scoreboard_leftover", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch_nway.md
Name: dispatch_nway

Overview:
- Parametrised N-wide dispatch buffer that sits between rename and the reservation stations (RS) and ROB.
- Accepts up to WIDTH renamed ops per cycle into an in-order queue.
- Snoops NUM_CDB CDBs to keep source-ready bits current, and applies branch clean/kill to queued ops.
- Each cycle, releases the longest in-order prefix of up to WIDTH ops for which the ROB and the target RS classes have room.

Parameters:
- WIDTH, 2: ops enqueued and dispatched per cycle.
- DEPTH, 8: queue entries; power of 2; must be >= 2*WIDTH.
- NUM_CDB, 2: CDB snoop ports.
- NUM_CLASS, 4: RS classes (int, mud, bra, mem).
- PHYS_REG_WIDTH, 6: physical register index width.
- COB_DEPTH, 4: branch-mask width.
- CNT_WIDTH, 4: width of the free-entry counts.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  WIDTH  per-slot op valid; slot 0 is oldest; valid bits are contiguous from slot 0
- in_op  in  WIDTH x disp_op_t  renamed op: class, prs1/prs2, ready bits, branch_mask, payload
- in_ready  out  1  all-or-nothing accept
- out_valid  out  WIDTH  dispatched ops, contiguous from slot 0
- out_op  out  WIDTH x disp_op_t  ops with snooped ready bits and cleaned masks applied
- rs_free  in  NUM_CLASS x CNT_WIDTH  free RS entries per class
- rob_free  in  CNT_WIDTH  free ROB entries
- cdb_valid  in  NUM_CDB  CDB broadcast valid
- cdb_prd  in  NUM_CDB x PHYS_REG_WIDTH  broadcast destination register
- br_valid  in  1  branch resolution
- br_tag  in  $clog2(COB_DEPTH)  branch tag
- br_clean  in  1  branch predicted correctly
- br_kill  in  1  branch mispredicted
- flush  in  1  full pipeline flush
- occupancy  out  $clog2(DEPTH)+1  queue count

Behaviour:
- Reset: queue empty; occupancy=0; out_valid=0; in_ready=1.
- Queue:
  - circular buffer with rptr/wptr, each one bit wider than $clog2(DEPTH); wrap modulo DEPTH.
  - full when the pointers differ only in the MSB.
- Enqueue:
  - in_ready = (DEPTH - occupancy_after_dequeue) >= WIDTH. Same-cycle dequeue counts, so a full queue can refill.
  - On in_ready & |in_valid, write popcount(in_valid) entries at wptr in slot order.
- Dispatch (combinational from queue head; data leaves on the next clk):
  - Slot k goes out only if slot k-1 goes out.
  - Slot k also needs: k+1 <= rob_free, and (count of slots 0..k with the same class) <= rs_free[class].
  - rptr advances by popcount(out_valid). No handshake back: consumers must accept every op presented.
- CDB snoop:
  - For every queue entry and every CDB port, set prsN_ready when cdb_valid & cdb_prd == prsN.
  - Ops written this cycle are snooped the same way.
  - out_op ready bits also OR in same-cycle CDB matches.
  - prd==0 broadcasts are ignored.
- Branch clean (br_valid & br_clean): clear branch_mask[br_tag] in all entries, in in_op being written, and in out_op.
- Branch kill (br_valid & br_kill):
  - Killed entries (mask bit set) form a suffix in program order.
  - wptr retracts to the oldest killed entry; out_valid is forced 0 for killed slots; incoming ops with the bit set are dropped.
- flush: pointers reset, out_valid=0, the in_op write is suppressed, in_ready=1 the next cycle.
- Priority: rst > flush > kill > clean. Kill and enqueue in the same cycle: write only non-killed incoming ops, starting at the retracted wptr.
- Latency: enqueue to earliest dispatch is 1 cycle.

Optional Feature:
- DISPATCH_BYPASS_EN defined: when the queue is empty (after kill/dequeue evaluation), in_op slots feed the dispatch selection directly the same cycle (0-cycle latency); only the undispatched remainder is written.
- DISPATCH_BYPASS_EN undefined: every op is written first; minimum latency is 1 cycle.

Decomposition:
- Package dispatch_pkg holds:
  - disp_op_t (class, prs1, prs1_ready, prs2, prs2_ready, branch_mask, payload)
  - rs_class_e
  - default widths
- Sub-module dispatch_select: the in-order prefix selector over WIDTH head slots, with per-class running counts and the rob_free limit. Pure combinational.

Test Plan:
- Credit limit: WIDTH=2, two int ops queued, rs_free[int]=1, rob_free=4 -> out_valid=01. Next cycle with rs_free[int]=1 -> out_valid=01.
- In-order blocking: head=mud with rs_free[mud]=0, slot1=int with rs_free[int]=3 -> out_valid=00. Dispatch resumes when rs_free[mud]=1.
- Full/refill: fill to 8 entries with rob_free=0 -> in_ready=0. Raise rob_free=2 -> in_ready=1 in the same cycle; occupancy stays 8 after simultaneous enqueue and dequeue.
- CDB snoop: queued op with prs1=5 not ready, cdb_prd[1]=5 valid -> op dispatches later with prs1_ready=1. A same-cycle match on the dispatching op is also set.
- Kill: queue ops with masks 0000,0000,0010,0010, br_kill tag=1 -> occupancy=2. Incoming ops with mask 0010 are dropped; those with mask 0000 are enqueued.
- Wrap and flush: run 20 single-op enqueue/dequeue cycles past the pointer wrap with order preserved, then flush -> occupancy=0, out_valid=0, in_ready=1.
